// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with 3-sample majority vote, parity and stop checks.
// Defining UART_RX_BREAK_DET_EN adds the break_det output and its break-detection logic.
module uart_rx_frame #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 break_det,
`endif
    output logic                 busy
);

    localparam int DIV   = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_V     = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] DATA_DONE = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rx_prev_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [OS_W-1:0]        os_q, os_d;
    logic [CNT_W-1:0]       bit_q, bit_d;
    logic [1:0]             hist_q, hist_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic                   rx_s, tick, vote_now, bit_end, vote, start_ok;

`ifdef UART_RX_BREAK_DET_EN
    logic                   brk_q, brk_d;
    logic                   par_bit_q, par_bit_d;
    assign start_ok  = !brk_q;
    assign break_det = brk_q;
`else
    assign start_ok  = 1'b1;
`endif

    assign rx_s     = sync_q[1];
    assign tick     = (div_q == DIV_LAST);
    assign vote_now = tick && (os_q == SMP_V);
    assign bit_end  = tick && (os_q == OS_LAST);
    // The two earlier samples sit in hist_q; the third is the live synced value.
    assign vote     = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

    assign data       = data_q;
    assign data_valid = dv_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        os_d         = os_q;
        bit_d        = bit_q;
        hist_d       = hist_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_d       = data_q;
        dv_d         = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        busy_d       = busy_q;
`ifdef UART_RX_BREAK_DET_EN
        brk_d        = brk_q;
        par_bit_d    = par_bit_q;
        if (brk_q && rx_s) brk_d = 1'b0;
`endif

        if (state_q == S_IDLE) begin
            div_d = '0;
            os_d  = '0;
        end else if (tick) begin
            div_d = '0;
            os_d  = os_q + 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (tick && (os_q == SMP_A || os_q == SMP_B)) hist_d = {hist_q[0], rx_s};

        case (state_q)
            S_IDLE: begin
                if (start_ok && rx_prev_q && !rx_s) begin
                    state_d = S_START;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (vote_now && vote) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (vote_now) begin
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                end
                if (bit_end && bit_q == DATA_DONE) begin
                    bit_d   = '0;
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (vote_now) begin
                    perr_d = ((^shreg_q) ^ vote) != (PARITY == 2);
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_d = vote;
`endif
                end
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Finish on the last stop vote so a start edge half a bit later is caught.
                if (vote_now) begin
                    ferr_d = ferr_q | !vote;
                    if (bit_q == STOP_LAST) begin
                        state_d      = S_IDLE;
                        busy_d       = 1'b0;
                        dv_d         = 1'b1;
                        data_d       = shreg_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_q | !vote;
`ifdef UART_RX_BREAK_DET_EN
                        if (shreg_q == '0 && !par_bit_q && (ferr_q | !vote)) brk_d = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            div_q        <= '0;
            os_q         <= '0;
            bit_q        <= '0;
            hist_q       <= '1;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            dv_q         <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q        <= 1'b0;
            par_bit_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], rx};
            rx_prev_q    <= rx_s;
            div_q        <= div_d;
            os_q         <= os_d;
            bit_q        <= bit_d;
            hist_q       <= hist_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_q       <= data_d;
            dv_q         <= dv_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_q        <= brk_d;
            par_bit_q    <= par_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: 8N1 and 8E2 instances, frames built bit by bit from a frame-level model.
// Break-detection checks are compiled in with UART_RX_BREAK_DET_EN.
module tb_uart_rx_frame;

    localparam int DIV     = (25_000_000 + 115200 * 16 / 2) / (115200 * 16);
    localparam int BIT_CLK = DIV * 16;

    typedef logic [9:0] rec_t;   // {frame_err, parity_err, data}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic [7:0] data0, data1;
    logic       dv0, dv1, perr0, perr1, ferr0, ferr1, busy0, busy1;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk0, brk1;
`endif

    int   checks = 0;
    int   failures = 0;
    rec_t cap0[$];
    rec_t cap1[$];

    always #5 clk = ~clk;

    uart_rx_frame dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .data(data0), .data_valid(dv0),
        .parity_err(perr0), .frame_err(ferr0),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(brk0),
`endif
        .busy(busy0)
    );

    uart_rx_frame #(.PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data(data1), .data_valid(dv1),
        .parity_err(perr1), .frame_err(ferr1),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(brk1),
`endif
        .busy(busy1)
    );

    always @(negedge clk) begin
        if (dv0) cap0.push_back({ferr0, perr0, data0});
        if (dv1) cap1.push_back({ferr1, perr1, data1});
    end

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0) rx0 = v; else rx1 = v;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                              input logic pbit, input logic s0, input logic s1, input int nstop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (use_par) drive_bit(sel, pbit);
        drive_bit(sel, s0);
        if (nstop == 2) drive_bit(sel, s1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({data0, dv0, perr0, ferr0, busy0} !== 12'h000) begin
            failures++;
            $display("FAIL reset_dut0 got=%h exp=000", {data0, dv0, perr0, ferr0, busy0});
        end
        checks++;
        if ({data1, dv1, perr1, ferr1, busy1} !== 12'h000) begin
            failures++;
            $display("FAIL reset_dut1 got=%h exp=000", {data1, dv1, perr1, ferr1, busy1});
        end
`ifdef UART_RX_BREAK_DET_EN
        checks++;
        if (brk0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_break got=%b exp=0", brk0);
        end
`endif
        @(posedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_basic_a5;
        rec_t exp_r;
        cap0.delete();
        exp_r = {1'b0, 1'b0, 8'hA5};
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1'b1, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cap0.size() != 1) begin
            failures++;
            $display("FAIL a5_count got=%0d exp=1", cap0.size());
        end else begin
            checks++;
            if (cap0[0] !== exp_r) begin
                failures++;
                $display("FAIL a5_word got=%h exp=%h", cap0[0], exp_r);
            end
        end
        checks++;
        if ({busy0, data0} !== {1'b0, 8'hA5}) begin
            failures++;
            $display("FAIL a5_hold got=%h exp=%h", {busy0, data0}, {1'b0, 8'hA5});
        end
    endtask

    task automatic test_parity_3c;
        rec_t exp_q[$];
        cap1.delete();
        send_frame(1, 8'h3C, 1, 1'b1, 1'b1, 1'b1, 2);
        exp_q.push_back({1'b0, 1'b1, 8'h3C});
        send_frame(1, 8'h3C, 1, 1'b0, 1'b1, 1'b1, 2);
        exp_q.push_back({1'b0, 1'b0, 8'h3C});
        repeat (20) @(posedge clk);
        checks++;
        if (cap1.size() != exp_q.size()) begin
            failures++;
            $display("FAIL par3c_count got=%0d exp=%0d", cap1.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (cap1[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL par3c_word[%0d] got=%h exp=%h", i, cap1[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_frame_err;
        rec_t exp_q[$];
        cap0.delete();
        send_frame(0, 8'h5A, 0, 1'b0, 1'b0, 1'b1, 1);
        exp_q.push_back({1'b1, 1'b0, 8'h5A});
        drive_bit(0, 1'b1);
        send_frame(0, 8'h01, 0, 1'b0, 1'b1, 1'b1, 1);
        exp_q.push_back({1'b0, 1'b0, 8'h01});
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cap0.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ferr_count got=%0d exp=%0d", cap0.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (cap0[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL ferr_word[%0d] got=%h exp=%h", i, cap0[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ferr0 !== 1'b0) begin
            failures++;
            $display("FAIL ferr_hold got=%b exp=0", ferr0);
        end
    endtask

    task automatic test_glitch;
        bit   saw_busy = 0;
        int   n = 0;
        rec_t exp_r;
        cap0.delete();
        rx0 = 1'b0;
        for (int i = 0; i < BIT_CLK * 3 / 10; i++) begin
            @(negedge clk);
            if (busy0) saw_busy = 1;
        end
        rx0 = 1'b1;
        while (busy0 && n < 2 * BIT_CLK) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (saw_busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_rise got=%b exp=1", saw_busy);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_fall got=%b exp=0 (timeout)", busy0);
        end
        repeat (BIT_CLK) @(posedge clk);
        checks++;
        if (cap0.size() != 0) begin
            failures++;
            $display("FAIL glitch_no_valid got=%0d exp=0", cap0.size());
        end
        exp_r = {1'b0, 1'b0, 8'h3E};
        send_frame(0, 8'h3E, 0, 1'b0, 1'b1, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++;
        if (cap0.size() != 1 || cap0[0] !== exp_r) begin
            failures++;
            $display("FAIL glitch_recover got_n=%0d got=%h exp=%h", cap0.size(),
                     (cap0.size() > 0) ? cap0[0] : 10'h0, exp_r);
        end
    endtask

    task automatic test_reset_mid;
        rec_t exp_r;
        cap0.delete();
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        rx0 = 1'b1;
        repeat (60) @(posedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy0, data0} !== 9'h000) begin
            failures++;
            $display("FAIL rstmid_clear got=%h exp=000", {busy0, data0});
        end
        @(posedge clk);
        rst_n = 1'b1;
        repeat (BIT_CLK - 64) @(posedge clk);
        for (int i = 5; i < 8; i++) drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        exp_r = {1'b0, 1'b0, 8'h81};
        send_frame(0, 8'h81, 0, 1'b0, 1'b1, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++;
        if (cap0.size() != 1 || cap0[0] !== exp_r) begin
            failures++;
            $display("FAIL rstmid_only_81 got_n=%0d got=%h exp=%h", cap0.size(),
                     (cap0.size() > 0) ? cap0[0] : 10'h0, exp_r);
        end
    endtask

    task automatic test_back_to_back;
        rec_t       exp_q[$];
        logic [7:0] d;
        logic       bad;
        cap0.delete();
        for (int k = 0; k < 12; k++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(0, d, 0, 1'b0, !bad, 1'b1, 1);
            exp_q.push_back({bad, 1'b0, d});
            if (bad) drive_bit(0, 1'b1);
        end
        repeat (20) @(posedge clk);
        checks++;
        if (cap0.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", cap0.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (cap0[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b_word[%0d] got=%h exp=%h", i, cap0[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random_parity;
        rec_t       exp_q[$];
        logic [7:0] d;
        logic       p, s0, s1;
        cap1.delete();
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            p  = 1'($urandom);
            s0 = ($urandom_range(0, 4) != 0);
            s1 = ($urandom_range(0, 4) != 0);
            send_frame(1, d, 1, p, s0, s1, 2);
            exp_q.push_back({!(s0 && s1), (^d) ^ p, d});
            if (!s1) drive_bit(1, 1'b1);
        end
        repeat (20) @(posedge clk);
        checks++;
        if (cap1.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rpar_count got=%0d exp=%0d", cap1.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (cap1[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rpar_word[%0d] got=%h exp=%h", i, cap1[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_break;
        rec_t exp_r;
        cap0.delete();
        exp_r = {1'b1, 1'b0, 8'h00};
        rx0 = 1'b0;
        repeat (15 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL break_busy got=%b exp=0", busy0);
        end
`ifdef UART_RX_BREAK_DET_EN
        checks++;
        if (brk0 !== 1'b1) begin
            failures++;
            $display("FAIL break_det_high got=%b exp=1", brk0);
        end
        rx0 = 1'b1;
        for (int i = 0; i < 10 && brk0; i++) @(negedge clk);
        checks++;
        if (brk0 !== 1'b0) begin
            failures++;
            $display("FAIL break_det_clear got=%b exp=0 (timeout)", brk0);
        end
`endif
        rx0 = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        checks++;
        if (cap0.size() != 1 || cap0[0] !== exp_r) begin
            failures++;
            $display("FAIL break_one_valid got_n=%0d got=%h exp=%h", cap0.size(),
                     (cap0.size() > 0) ? cap0[0] : 10'h0, exp_r);
        end
        send_frame(0, 8'h77, 0, 1'b0, 1'b1, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++;
        if (cap0.size() != 2 || cap0[cap0.size() - 1] !== {2'b00, 8'h77}) begin
            failures++;
            $display("FAIL break_recover got_n=%0d exp_n=2 last=%h exp=077", cap0.size(),
                     (cap0.size() > 0) ? cap0[cap0.size() - 1] : 10'h0);
        end
    endtask

    initial begin
        test_reset;
        test_basic_a5;
        test_parity_3c;
        test_frame_err;
        test_glitch;
        test_reset_mid;
        test_back_to_back;
        test_random_parity;
        test_break;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
